// File: rtl/cv32e40p_tmr_fault_manager.sv
// rtl/cv32e40p_tmr_fault_manager.sv - per-lane TMR error accounting, resync handshake and fatal escalation
module cv32e40p_tmr_fault_manager #(
    parameter int CNT_W   = 4,
    parameter int THRESH  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             err_valid_i,
    input  logic             err_a_i,
    input  logic             err_b_i,
    input  logic             err_c_i,
    input  logic             clear_i,
    input  logic             resync_ack_i,
    output logic             resync_req_o,
    output logic [2:0]       lane_faulty_o,
    output logic [CNT_W-1:0] cnt_a_o,
    output logic [CNT_W-1:0] cnt_b_o,
    output logic [CNT_W-1:0] cnt_c_o,
    output logic             fatal_o
);

    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  THR      = CNT_W'(THRESH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESYNC,
        ST_FATAL
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_a_q, cnt_b_q, cnt_c_q;
    logic [CNT_W-1:0] cnt_a_d, cnt_b_d, cnt_c_d;
    logic [2:0]       faulty_q, faulty_d;
    logic [TMO_W-1:0] tmo_q;
    logic             resync_q;
    logic             fatal_q;

    logic [2:0]       eff;
    logic             single_evt;
    logic             multi_evt;
    logic             two_faulty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Flags from lanes already marked faulty no longer count as evidence.
    always_comb begin
        eff        = {err_c_i, err_b_i, err_a_i} & ~faulty_q;
        single_evt = err_valid_i && ($countones(eff) == 1);
        multi_evt  = err_valid_i && ($countones(eff) >= 2);
        cnt_a_d    = (single_evt && eff[0]) ? sat_inc(cnt_a_q) : cnt_a_q;
        cnt_b_d    = (single_evt && eff[1]) ? sat_inc(cnt_b_q) : cnt_b_q;
        cnt_c_d    = (single_evt && eff[2]) ? sat_inc(cnt_c_q) : cnt_c_q;
        faulty_d   = faulty_q | ({cnt_c_d == THR, cnt_b_d == THR, cnt_a_d == THR}
                                 & eff & {3{single_evt}});
        two_faulty = ($countones(faulty_d) >= 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            cnt_c_q  <= '0;
            faulty_q <= '0;
            tmo_q    <= '0;
            resync_q <= 1'b0;
            fatal_q  <= 1'b0;
        end else if (clear_i) begin
            state_q  <= ST_IDLE;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            cnt_c_q  <= '0;
            faulty_q <= '0;
            tmo_q    <= '0;
            resync_q <= 1'b0;
            fatal_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (multi_evt) begin
                        state_q <= ST_FATAL;
                        fatal_q <= 1'b1;
                    end else if (single_evt) begin
                        cnt_a_q  <= cnt_a_d;
                        cnt_b_q  <= cnt_b_d;
                        cnt_c_q  <= cnt_c_d;
                        faulty_q <= faulty_d;
                        if (two_faulty) begin
                            state_q <= ST_FATAL;
                            fatal_q <= 1'b1;
                        end else begin
                            state_q  <= ST_RESYNC;
                            resync_q <= 1'b1;
                            tmo_q    <= '0;
                        end
                    end
                end
                ST_RESYNC: begin
                    // An ack on the last allowed cycle still counts.
                    if (resync_ack_i) begin
                        state_q  <= ST_IDLE;
                        resync_q <= 1'b0;
                        tmo_q    <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q  <= ST_FATAL;
                        resync_q <= 1'b0;
                        fatal_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_FATAL: begin
                    state_q <= ST_FATAL;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    resync_q <= 1'b0;
                    fatal_q  <= 1'b0;
                end
            endcase
        end
    end

    assign resync_req_o  = resync_q;
    assign fatal_o       = fatal_q;
    assign lane_faulty_o = faulty_q;
    assign cnt_a_o       = cnt_a_q;
    assign cnt_b_o       = cnt_b_q;
    assign cnt_c_o       = cnt_c_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// tb/tb_cv32e40p_tmr_fault_manager.sv - directed and randomized checks against a behavioural fault-manager model
module tb_cv32e40p_tmr_fault_manager;

    localparam int CNT_W   = 4;
    localparam int THRESH  = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             err_valid_i = 1'b0;
    logic             err_a_i = 1'b0, err_b_i = 1'b0, err_c_i = 1'b0;
    logic             clear_i = 1'b0;
    logic             resync_ack_i = 1'b0;
    logic             resync_req_o;
    logic [2:0]       lane_faulty_o;
    logic [CNT_W-1:0] cnt_a_o, cnt_b_o, cnt_c_o;
    logic             fatal_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0 = waiting for errors, 1 = resync pending, 2 = dead.
    int         m_mode;
    int         m_cnt[3];
    logic [2:0] m_faulty;
    int         m_wait;

    cv32e40p_tmr_fault_manager #(
        .CNT_W(CNT_W), .THRESH(THRESH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .err_valid_i(err_valid_i),
        .err_a_i(err_a_i), .err_b_i(err_b_i), .err_c_i(err_c_i),
        .clear_i(clear_i), .resync_ack_i(resync_ack_i),
        .resync_req_o(resync_req_o), .lane_faulty_o(lane_faulty_o),
        .cnt_a_o(cnt_a_o), .cnt_b_o(cnt_b_o), .cnt_c_o(cnt_c_o),
        .fatal_o(fatal_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0;
        m_wait = 0;
        m_faulty = 3'b000;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endtask

    task automatic model_edge(input logic v, input logic [2:0] e, input logic clr, input logic ack);
        logic [2:0] live;
        int k;
        if (clr) begin
            model_reset();
        end else if (m_mode == 0 && v) begin
            live = e & ~m_faulty;
            if ($countones(live) >= 2) begin
                m_mode = 2;
            end else if ($countones(live) == 1) begin
                k = live[0] ? 0 : (live[1] ? 1 : 2);
                if (m_cnt[k] < (1 << CNT_W) - 1) m_cnt[k]++;
                if (m_cnt[k] == THRESH) m_faulty[k] = 1'b1;
                m_mode = ($countones(m_faulty) >= 2) ? 2 : 1;
                m_wait = 0;
            end
        end else if (m_mode == 1) begin
            if (ack) begin
                m_mode = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) m_mode = 2;
            end
        end
    endtask

    task automatic step(input logic v, input logic [2:0] e, input logic clr, input logic ack);
        err_valid_i  = v;
        {err_c_i, err_b_i, err_a_i} = e;
        clear_i      = clr;
        resync_ack_i = ack;
        @(posedge clk);
        model_edge(v, e, clr, ack);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({resync_req_o, fatal_o, lane_faulty_o, cnt_a_o, cnt_b_o, cnt_c_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%0b fatal=%0b faulty=%b cnt=%0d/%0d/%0d want all zero",
                     resync_req_o, fatal_o, lane_faulty_o, cnt_a_o, cnt_b_o, cnt_c_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_error();
        step(0, 3'b000, 1, 0);
        step(1, 3'b010, 0, 0);
        n_tests++;
        if (cnt_b_o !== 4'd1 || resync_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_event: got cnt_b=%0d req=%0b want 1/1", cnt_b_o, resync_req_o);
        end
        step(0, 3'b000, 0, 0);
        step(1, 3'b001, 0, 0);
        n_tests++;
        if (resync_req_o !== 1'b1 || cnt_a_o !== 4'd0) begin
            n_fail++;
            $display("FAIL resync_ignores_events: got req=%0b cnt_a=%0d want 1/0", resync_req_o, cnt_a_o);
        end
        step(0, 3'b000, 0, 1);
        n_tests++;
        if (resync_req_o !== 1'b0 || fatal_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: got req=%0b fatal=%0b want 0/0", resync_req_o, fatal_o);
        end
        step(1, 3'b010, 0, 0);
        n_tests++;
        if (cnt_b_o !== 4'd2 || resync_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL back_in_idle: got cnt_b=%0d req=%0b want 2/1", cnt_b_o, resync_req_o);
        end
    endtask

    task automatic test_threshold();
        step(0, 3'b000, 1, 0);
        for (int i = 0; i < THRESH; i++) begin
            step(1, 3'b001, 0, 0);
            step(0, 3'b000, 0, 1);
        end
        n_tests++;
        if (cnt_a_o !== 4'd4 || lane_faulty_o !== 3'b001 || fatal_o !== 1'b0) begin
            n_fail++;
            $display("FAIL threshold: got cnt_a=%0d faulty=%b fatal=%0b want 4/001/0", cnt_a_o, lane_faulty_o, fatal_o);
        end
        step(1, 3'b001, 0, 0);
        n_tests++;
        if (cnt_a_o !== 4'd4 || resync_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL faulty_lane_ignored: got cnt_a=%0d req=%0b want 4/0", cnt_a_o, resync_req_o);
        end
        step(1, 3'b011, 0, 0);
        n_tests++;
        if (cnt_b_o !== 4'd1 || resync_req_o !== 1'b1 || fatal_o !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_pair: got cnt_b=%0d req=%0b fatal=%0b want 1/1/0", cnt_b_o, resync_req_o, fatal_o);
        end
    endtask

    task automatic test_no_majority();
        step(0, 3'b000, 1, 0);
        step(1, 3'b010, 0, 0);
        step(0, 3'b000, 0, 1);
        step(1, 3'b111, 0, 0);
        n_tests++;
        if (fatal_o !== 1'b1 || resync_req_o !== 1'b0 || cnt_b_o !== 4'd1 || cnt_a_o !== 4'd0) begin
            n_fail++;
            $display("FAIL no_majority: got fatal=%0b req=%0b cnt_a=%0d cnt_b=%0d want 1/0/0/1",
                     fatal_o, resync_req_o, cnt_a_o, cnt_b_o);
        end
        step(1, 3'b100, 0, 1);
        n_tests++;
        if (fatal_o !== 1'b1 || cnt_c_o !== 4'd0) begin
            n_fail++;
            $display("FAIL fatal_frozen: got fatal=%0b cnt_c=%0d want 1/0", fatal_o, cnt_c_o);
        end
        step(0, 3'b000, 1, 0);
        n_tests++;
        if ({resync_req_o, fatal_o, lane_faulty_o, cnt_a_o, cnt_b_o, cnt_c_o} !== '0) begin
            n_fail++;
            $display("FAIL clear_from_fatal: got fatal=%0b cnt_b=%0d want all zero", fatal_o, cnt_b_o);
        end
    endtask

    task automatic test_timeout();
        step(0, 3'b000, 1, 0);
        step(1, 3'b100, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 3'b000, 0, 0);
        n_tests++;
        if (fatal_o !== 1'b0 || resync_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got fatal=%0b req=%0b want 0/1", fatal_o, resync_req_o);
        end
        step(0, 3'b000, 0, 0);
        n_tests++;
        if (fatal_o !== 1'b1 || resync_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fatal: got fatal=%0b req=%0b want 1/0", fatal_o, resync_req_o);
        end
        step(0, 3'b000, 1, 0);
        step(1, 3'b100, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 3'b000, 0, 0);
        step(0, 3'b000, 0, 1);
        n_tests++;
        if (fatal_o !== 1'b0 || resync_req_o !== 1'b0 || cnt_c_o !== 4'd1) begin
            n_fail++;
            $display("FAIL ack_last_cycle: got fatal=%0b req=%0b cnt_c=%0d want 0/0/1", fatal_o, resync_req_o, cnt_c_o);
        end
    endtask

    task automatic test_double_fault();
        step(0, 3'b000, 1, 0);
        for (int i = 0; i < THRESH; i++) begin
            step(1, 3'b001, 0, 0);
            step(0, 3'b000, 0, 1);
        end
        for (int i = 0; i < THRESH - 1; i++) begin
            step(1, 3'b100, 0, 0);
            step(0, 3'b000, 0, 1);
        end
        n_tests++;
        if (fatal_o !== 1'b0 || cnt_c_o !== 4'd3) begin
            n_fail++;
            $display("FAIL double_fault_pre: got fatal=%0b cnt_c=%0d want 0/3", fatal_o, cnt_c_o);
        end
        step(1, 3'b100, 0, 0);
        n_tests++;
        if (fatal_o !== 1'b1 || lane_faulty_o !== 3'b101 || cnt_c_o !== 4'd4 || resync_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL double_fault: got fatal=%0b faulty=%b cnt_c=%0d req=%0b want 1/101/4/0",
                     fatal_o, lane_faulty_o, cnt_c_o, resync_req_o);
        end
    endtask

    task automatic test_priority();
        step(0, 3'b000, 1, 0);
        step(1, 3'b100, 0, 0);
        step(0, 3'b000, 1, 1);
        n_tests++;
        if ({resync_req_o, fatal_o, lane_faulty_o, cnt_a_o, cnt_b_o, cnt_c_o} !== '0) begin
            n_fail++;
            $display("FAIL clear_vs_ack: got req=%0b cnt_c=%0d want all zero", resync_req_o, cnt_c_o);
        end
        step(1, 3'b001, 1, 0);
        n_tests++;
        if (resync_req_o !== 1'b0 || cnt_a_o !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_vs_event: got req=%0b cnt_a=%0d want 0/0", resync_req_o, cnt_a_o);
        end
    endtask

    task automatic test_async_reset();
        step(0, 3'b000, 1, 0);
        step(1, 3'b001, 0, 0);
        err_valid_i = 1'b0;
        {err_c_i, err_b_i, err_a_i} = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (resync_req_o !== 1'b0 || cnt_a_o !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: got req=%0b cnt_a=%0d want 0/0", resync_req_o, cnt_a_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 3'b010, 0, 0);
        n_tests++;
        if (resync_req_o !== 1'b1 || cnt_b_o !== 4'd1) begin
            n_fail++;
            $display("FAIL after_reset_idle: got req=%0b cnt_b=%0d want 1/1", resync_req_o, cnt_b_o);
        end
    endtask

    task automatic test_random();
        logic v, clr, ack;
        logic [2:0] e;
        int bad = 0;
        step(0, 3'b000, 1, 0);
        for (int i = 0; i < 1500; i++) begin
            v   = ($urandom_range(0, 1) == 1);
            e   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) e = 3'b001 << $urandom_range(0, 2);
            ack = ($urandom_range(0, 3) == 0);
            clr = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
            step(v, e, clr, ack);
            n_tests++;
            if (resync_req_o !== (m_mode == 1) || fatal_o !== (m_mode == 2) || lane_faulty_o !== m_faulty ||
                cnt_a_o !== CNT_W'(m_cnt[0]) || cnt_b_o !== CNT_W'(m_cnt[1]) || cnt_c_o !== CNT_W'(m_cnt[2])) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got req=%0b fatal=%0b faulty=%b cnt=%0d/%0d/%0d want req=%0b fatal=%0b faulty=%b cnt=%0d/%0d/%0d",
                             i, resync_req_o, fatal_o, lane_faulty_o, cnt_a_o, cnt_b_o, cnt_c_o,
                             m_mode == 1, m_mode == 2, m_faulty, m_cnt[0], m_cnt[1], m_cnt[2]);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_error();
        test_threshold();
        test_no_majority();
        test_timeout();
        test_double_fault();
        test_priority();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
